// File: rtl/async_fifo_rd_stream_pkg.sv
// Shared types for the asynchronous FIFO read-side output stage.
package async_fifo_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } rd_buf_state_e;

  localparam int RD_BUF_DEPTH = 2;

endpackage

// File: rtl/async_fifo_rd_stream_if.sv
// FIFO read channel plus outgoing valid/ready stream of the read-side stage.
interface async_fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_pop;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            out_level;

  // Stage side: consumes the FIFO head, produces the stream.
  modport master (
    input  fifo_empty, fifo_data, flush, out_ready,
    output fifo_pop, out_valid, out_data, out_level
  );

  // Environment side: FIFO plus stream consumer.
  modport slave (
    output fifo_empty, fifo_data, flush, out_ready,
    input  fifo_pop, out_valid, out_data, out_level
  );

endinterface

// File: rtl/async_fifo_rd_stream.sv
// Pops a show-ahead FIFO into a 2-entry skid buffer and presents the words
// on a flop-driven valid/ready stream; out_ready never reaches fifo_pop.
module async_fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  async_fifo_rd_stream_if.master bus
);

  rd_buf_state_e         state_r;
  rd_buf_state_e         next_state_s;
  logic [DATA_WIDTH-1:0] ent0_r;
  logic [DATA_WIDTH-1:0] ent1_r;
  logic [DATA_WIDTH-1:0] ent0_d_s;
  logic                  ent0_we_s;
  logic                  ent1_we_s;
  logic                  pop_s;
  logic                  take_s;
  logic                  valid_s;

  // Pop depends only on local state and the FIFO flag, never on out_ready.
  assign pop_s   = reset_n && !bus.fifo_empty && !bus.flush && (state_r != BUF_FULL);
  assign valid_s = (state_r != BUF_EMPTY);
  assign take_s  = valid_s && bus.out_ready;

  assign bus.fifo_pop  = pop_s;
  assign bus.out_valid = valid_s;
  assign bus.out_data  = ent0_r;
  assign bus.out_level = 2'(state_r);

  // Next-state and entry write-enable decode.
  always_comb begin
    next_state_s = state_r;
    ent0_we_s    = 1'b0;
    ent1_we_s    = 1'b0;
    ent0_d_s     = bus.fifo_data;
    if (bus.flush) begin
      next_state_s = BUF_EMPTY;
    end else begin
      case (state_r)
        BUF_EMPTY: begin
          if (pop_s) begin
            next_state_s = BUF_ONE;
            ent0_we_s    = 1'b1;
          end else begin
            next_state_s = BUF_EMPTY;
          end
        end
        BUF_ONE: begin
          if (pop_s && take_s) begin
            next_state_s = BUF_ONE;
            ent0_we_s    = 1'b1;
          end else if (pop_s) begin
            next_state_s = BUF_FULL;
            ent1_we_s    = 1'b1;
          end else if (take_s) begin
            next_state_s = BUF_EMPTY;
          end else begin
            next_state_s = BUF_ONE;
          end
        end
        BUF_FULL: begin
          if (take_s) begin
            next_state_s = BUF_ONE;
            ent0_we_s    = 1'b1;
            ent0_d_s     = ent1_r;
          end else begin
            next_state_s = BUF_FULL;
          end
        end
        default: begin
          next_state_s = BUF_EMPTY;
        end
      endcase
    end
  end

  // State and entry registers; entries change only on capture or shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= BUF_EMPTY;
      ent0_r  <= {DATA_WIDTH{1'b0}};
      ent1_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (ent0_we_s) begin
        ent0_r <= ent0_d_s;
      end
      if (ent1_we_s) begin
        ent1_r <= bus.fifo_data;
      end
    end
  end

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Directed bench: a queue-modelled FIFO feeds the stage, a scoreboard checks takes.
module tb_async_fifo_rd_stream;

  logic clk;
  logic reset_n;

  async_fifo_rd_stream_if #(.DATA_WIDTH(32)) bus ();

  async_fifo_rd_stream #(.DATA_WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;
  int unsigned takes = 0;
  int unsigned cov_shift = 0;
  int unsigned cov_pop_take = 0;

  logic        s_pop;
  logic        s_valid;
  logic        s_take;
  logic [1:0]  s_level;
  logic [31:0] s_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic drive_fifo();
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0000_0000;
  endtask

  // One clock: starts and ends at a negedge, samples 1 time unit after driving.
  task automatic cycle();
    logic [31:0] exp_w;
    drive_fifo();
    #1;
    s_pop   = bus.fifo_pop;
    s_valid = bus.out_valid;
    s_level = bus.out_level;
    s_data  = bus.out_data;
    s_take  = s_valid && bus.out_ready;
    if (s_take) begin
      takes++;
      exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
      check("take_data", s_data, exp_w);
      if (s_level == 2'd2) cov_shift++;
      if (s_level == 2'd1 && s_pop) cov_pop_take++;
    end
    if (s_pop) begin
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      else check("pop_when_empty", 32'd1, 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while ((exp_q.size() != 0) && (n < 60)) begin
      cycle();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    cycle();
    check("drain_idle_valid", 32'(s_valid), 32'd0);
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    push_word(32'hA5A5_0001);
    drive_fifo();

    // Reset with a non-empty FIFO
    @(negedge clk);
    #1;
    check("rst_pop", 32'(bus.fifo_pop), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_level", 32'(bus.out_level), 32'd0);
    check("rst_data", bus.out_data, 32'h0000_0000);
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
    check("first_pop", 32'(s_pop), 32'd1);
    check("first_valid_early", 32'(s_valid), 32'd0);
    cycle();
    check("first_valid", 32'(s_valid), 32'd1);
    check("first_data", s_data, 32'hA5A5_0001);
    check("first_level", 32'(s_level), 32'd1);
    drain();

    // Full-throughput streaming 1..16
    for (int i = 1; i <= 16; i++) push_word(32'(i));
    bus.out_ready = 1'b1;
    takes = 0;
    cycle();
    check("stream_first_pop", 32'(s_pop), 32'd1);
    for (int i = 0; i < 16; i++) begin
      cycle();
      check("stream_level", 32'(s_level), 32'd1);
      check("stream_take", 32'(s_take), 32'd1);
    end
    check("stream_takes", 32'(takes), 32'd16);
    drain();

    // Backpressure with words 1..5
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_word(32'(i));
    cycle();
    check("bp_pop0", 32'(s_pop), 32'd1);
    cycle();
    check("bp_pop1", 32'(s_pop), 32'd1);
    check("bp_level1", 32'(s_level), 32'd1);
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("bp_stall_pop", 32'(s_pop), 32'd0);
      check("bp_stall_level", 32'(s_level), 32'd2);
      check("bp_stall_data", s_data, 32'd1);
      check("bp_fifo_left", 32'(fifo_q.size()), 32'd3);
    end
    bus.out_ready = 1'b1;
    cycle();
    check("bp_release_take", 32'(s_take), 32'd1);
    check("bp_release_pop", 32'(s_pop), 32'd0);
    cycle();
    check("bp_resume_pop", 32'(s_pop), 32'd1);
    drain();

    // Toggling ready from a prefilled buffer: exercises the shift in BUF_FULL
    bus.out_ready = 1'b0;
    push_word(32'h0000_0A01);
    push_word(32'h0000_0A02);
    cycle();
    cycle();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) push_word(32'h0000_0B00 + 32'(i));
      bus.out_ready = (i % 2 == 0);
      cycle();
    end
    drain();
    // Toggling ready from empty: exercises pop-and-take in BUF_ONE
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) push_word(32'h0000_0C00 + 32'(i));
      bus.out_ready = (i % 2 == 0);
      cycle();
    end
    drain();
    check("cov_shift", 32'(cov_shift != 0), 32'd1);
    check("cov_pop_take", 32'(cov_pop_take != 0), 32'd1);

    // Flush while full
    bus.out_ready = 1'b0;
    push_word(32'h0000_0100);
    push_word(32'h0000_0101);
    push_word(32'h0000_0102);
    cycle();
    cycle();
    bus.flush = 1'b1;
    cycle();
    check("flush_pop", 32'(s_pop), 32'd0);
    check("flush_level_before", 32'(s_level), 32'd2);
    bus.flush = 1'b0;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    cycle();
    check("flush_valid_after", 32'(s_valid), 32'd0);
    check("flush_level_after", 32'(s_level), 32'd0);
    check("flush_pop_resume", 32'(s_pop), 32'd1);
    drain();

    // Asynchronous reset while full, between clock edges
    bus.out_ready = 1'b0;
    push_word(32'h0000_0200);
    push_word(32'h0000_0201);
    push_word(32'h0000_0202);
    cycle();
    cycle();
    drive_fifo();
    #1;
    check("arst_pre_level", 32'(bus.out_level), 32'd2);
    check("arst_pre_data", bus.out_data, 32'h0000_0200);
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_level", 32'(bus.out_level), 32'd0);
    check("arst_data", bus.out_data, 32'h0000_0000);
    check("arst_pop", 32'(bus.fifo_pop), 32'd0);
    fifo_q.delete();
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    cycle();
    check("arst_release_valid", 32'(s_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/async_fifo_rd_stream.md
# async_fifo_rd_stream

Read-side output stage placed directly downstream of the asynchronous FIFO's read channel, in the read clock domain. It pops the show-ahead FIFO whenever it has buffer space and presents the words on a registered valid/ready stream through a 2-entry skid buffer. There is no combinational path from `out_ready` to `fifo_pop`, and the FIFO keeps full throughput.

## Interface
- `DATA_WIDTH`, 32, word width; equals the FIFO data width.
- `clk`  input  1  read clock; same clock as the FIFO read channel.
- `reset_n`  input  1  asynchronous, active-low reset.
- `fifo_empty`  input  1  FIFO empty flag.
- `fifo_data`  input  DATA_WIDTH  FIFO head word, show-ahead: valid in any cycle where `fifo_empty`=0.
- `fifo_pop`  output  1  FIFO pop; combinational from local state and `fifo_empty` only.
- `flush`  input  1  synchronous clear of buffered words.
- `out_valid`  output  1  stream valid.
- `out_ready`  input  1  stream ready from the consumer.
- `out_data`  output  DATA_WIDTH  stream data; driven directly from a flop.
- `out_level`  output  2  number of buffered words, 0..2.

## Operation
- Storage:
  - `ent0` is always the head; `ent1` is the second word.
  - State is `BUF_EMPTY` (0 words), `BUF_ONE` (1), `BUF_FULL` (2).
  - `out_level` encodes the state as 0/1/2.
- Pop: `fifo_pop = !fifo_empty && !flush && state!=BUF_FULL`.
- Word capture: when `fifo_pop`=1, `fifo_data` is captured at the same edge.
- `take = out_valid && out_ready`.
- `BUF_EMPTY`:
  - pop → `BUF_ONE`; `ent0`←`fifo_data`.
- `BUF_ONE`:
  - pop, no take → `BUF_FULL`; `ent1`←`fifo_data`.
  - take, no pop → `BUF_EMPTY`.
  - pop and take → stay in `BUF_ONE`; `ent0`←`fifo_data`.
  - Neither → hold.
- `BUF_FULL`:
  - Pop is inhibited.
  - take → `BUF_ONE`; `ent0`←`ent1`.
  - No take → hold. `out_data` and `out_valid` stay stable until taken.
- `out_valid = (state!=BUF_EMPTY)`; `out_data = ent0`.
- Flush:
  - `flush`=1 → next state `BUF_EMPTY`, regardless of take or `fifo_empty`.
  - No pop is issued that cycle.
  - A take in the same cycle is still a legal handshake; the consumer sees `ent0` as accepted.
- Entry registers are written only on a capture or shift. Contents of unused entries are don't-care, but `out_data` reads 0 after reset until the first capture.
- Popping while the FIFO is empty cannot occur, because `fifo_pop` is gated by `fifo_empty`.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - state=`BUF_EMPTY`, `out_valid`=0, `out_level`=0, `out_data`=0, `ent1`=0.
  - `fifo_pop`=0 while `reset_n`=0.
- Latency: `fifo_empty` falls in cycle t → `fifo_pop`=1 in cycle t → `out_valid`=1 and `out_data`=word from cycle t+1.
- Throughput: with `out_ready` held 1, one word per cycle in steady state, with the buffer in `BUF_ONE`.
- Backpressure: `out_ready`=0 while the FIFO is non-empty.
  - The buffer fills in 2 cycles, then `fifo_pop`=0.
  - The first `out_ready`=1 re-enables pop in the following cycle.
- Reset mid-operation: buffered words are discarded immediately and outputs return to their reset values. This is a system-level reset; the FIFO is reset simultaneously.
- Consumer rule: once `out_valid`=1, the stage never deasserts it or changes `out_data` without a take, except on reset or flush.

## Structure
- `async_fifo_pkg` holds:
  - `typedef enum logic [1:0] {BUF_EMPTY=2'd0, BUF_ONE=2'd1, BUF_FULL=2'd2} rd_buf_state_e`.
  - `localparam RD_BUF_DEPTH = 2`.
- Single module with no sub-module. The 2-entry shift buffer is too small to justify one.
- Integration: `fifo_empty`/`fifo_data`/`fifo_pop` connect to `read_fifo_empty`/`read_data`/`read_fifo_pop`. `clk`/`reset_n` connect to `read_clk`/`read_reset_n`.

## Test plan
- Reset with `fifo_empty`=0 and `fifo_data`=32'hA5A5_0001 → `fifo_pop`=0 during reset and `out_valid`=0. First pop in the first cycle after release; `out_valid`=1 one cycle later with `out_data`=32'hA5A5_0001.
- Stream words 1..16 with `out_ready`=1 → 16 takes on consecutive cycles, in order, with `out_level` constant at 1.
- Hold `out_ready`=0 while the FIFO holds words 1..5 → exactly 2 pops, then `fifo_pop`=0, `out_level`=2, `out_data`=1 stable. Raising `out_ready` then yields 1,2,3,4,5 with no loss or duplication.
- Toggle `out_ready` 1,0,1,0 against a FIFO that empties every other cycle → the sequence is preserved. Cover the pop-and-take transition in `BUF_ONE` and the shift transition in `BUF_FULL`.
- In `BUF_FULL`, assert `flush` for one cycle with `fifo_empty`=0 → no pop that cycle, `out_valid`=0 next cycle, and a pop resumes in the cycle after the flush.
- Assert `reset_n`=0 asynchronously in `BUF_FULL` → `out_valid`, `out_level` and `out_data` clear immediately, without a clock edge.
